// File: rtl/bdemux_8.sv
// Registered 1-to-8 demultiplexer: each of eight slots buffers one word until its
// consumer acknowledges it; a write to an occupied, unacknowledged slot is dropped and latches err.
module bdemux_8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] d,
    input  logic             wr,
    output logic             ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic [WIDTH-1:0] H,
    output logic [7:0]       full,
    input  logic [7:0]       ack,
    output logic             err
);

    logic [WIDTH-1:0] slot_q [8];
    logic [WIDTH-1:0] slot_d [8];
    logic [7:0]       full_q;
    logic [7:0]       full_d;
    logic             err_q;
    logic             err_d;
    logic             accept_s;

    // A same-cycle ack frees the slot for the incoming write.
    assign ready    = ~full_q[s] | ack[s];
    assign accept_s = wr & ready;

    // Next-state: acks drain, an accepted write then (re)fills its slot.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            slot_d[i] = slot_q[i];
        end
        full_d = full_q & ~ack;
        err_d  = err_q;
        if (accept_s) begin
            slot_d[s] = d;
            full_d[s] = 1'b1;
        end else if (wr) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset discards every held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= {WIDTH{1'b0}};
            end
            full_q <= 8'h00;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= slot_d[i];
            end
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    assign A    = slot_q[0];
    assign B    = slot_q[1];
    assign C    = slot_q[2];
    assign D    = slot_q[3];
    assign E    = slot_q[4];
    assign F    = slot_q[5];
    assign G    = slot_q[6];
    assign H    = slot_q[7];
    assign full = full_q;
    assign err  = err_q;

endmodule
